regfile_wr_arbiter: RTL and testbench

- Shares the register file's single write port (we3/wa3/wd3) between NREQ requesters, e.g. CPU writeback, I/O loader and debug port.
- Round-robin arbitration with a per-requester valid/ready handshake and one registered output stage.
- Sits between the requesters and regfile; the regfile read ports are untouched.

---
 rtl/regfile_wr_arbiter_pkg.sv | 13 +
 rtl/regfile_wr_arbiter_rr_pick.sv | 31 +++
 rtl/regfile_wr_arbiter.sv | 109 ++++++++++
 tb/tb_regfile_wr_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared constants and helpers for the regfile write-port arbiter.
package regfile_wr_arbiter_pkg;

    localparam int AW_DEF   = 4;
    localparam int DW_DEF   = 16;
    localparam int REG_ZERO = 0;

    // Width of a requester index; a single requester still needs one bit.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regfile_wr_arbiter_rr_pick.sv
// Combinational round-robin selector: first set bit of valid at or after ptr,
// wrapping modulo N, returned as a one-hot grant plus its index.
module regfile_wr_arbiter_rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    logic found;

    // Scan distances 0..N-1 from ptr; the nearest valid requester wins.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!found && valid[i] && (((i - int'(ptr) + N) % N) == k)) begin
                    found  = 1'b1;
                    gnt[i] = 1'b1;
                    idx    = IW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the regfile write port (we3/wa3/wd3) among NREQ
// requesters. Optional macro REGFILE_WR_ARB_PRIO0_EN gives port 0 fixed top priority.
module regfile_wr_arbiter
    import regfile_wr_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int AW   = AW_DEF,
    parameter int DW   = DW_DEF,
    localparam int IW  = id_w(NREQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    output logic               we3,
    output logic [AW-1:0]      wa3,
    output logic [DW-1:0]      wd3,
    output logic [IW-1:0]      grant_id,
    output logic               drop_r0
);

`ifdef REGFILE_WR_ARB_PRIO0_EN
    // Port 0 bypasses the ring, so the pointer only ever visits 1..NREQ-1.
    localparam bit            PRIO0   = 1'b1;
    localparam logic [IW-1:0] PTR_RST = IW'(1);
`else
    localparam bit            PRIO0   = 1'b0;
    localparam logic [IW-1:0] PTR_RST = '0;
`endif

    logic [IW-1:0]   ptr, ptr_nxt, win, rr_idx;
    logic [NREQ-1:0] rr_valid, rr_gnt, gnt;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_data;
    logic            xfer;

    assign rr_valid = PRIO0 ? (req_valid & ~NREQ'(1)) : req_valid;

    regfile_wr_arbiter_rr_pick #(.N(NREQ), .IW(IW)) u_pick (
        .valid (rr_valid),
        .ptr   (ptr),
        .gnt   (rr_gnt),
        .idx   (rr_idx)
    );

    always_comb begin
        gnt = rr_gnt;
        win = rr_idx;
        if (PRIO0 && req_valid[0]) begin
            gnt = NREQ'(1);
            win = '0;
        end
    end

    assign req_ready = (reset && !stall) ? gnt : '0;
    assign xfer      = |req_ready;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_addr = req_addr[i*AW +: AW];
                sel_data = req_data[i*DW +: DW];
            end
        end
    end

    // Pointer moves just past the winner; fixed-priority port-0 grants leave it alone.
    always_comb begin
        ptr_nxt = ptr;
        if (xfer && !(PRIO0 && win == '0)) begin
            if (win == IW'(NREQ-1)) ptr_nxt = PTR_RST;
            else                    ptr_nxt = win + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr      <= PTR_RST;
            we3      <= 1'b0;
            wa3      <= '0;
            wd3      <= '0;
            grant_id <= '0;
            drop_r0  <= 1'b0;
        end else begin
            ptr     <= ptr_nxt;
            we3     <= 1'b0;
            drop_r0 <= 1'b0;
            if (xfer) begin
                grant_id <= win;
                // Register 0 is hardwired; accept the write but never issue it.
                if (sel_addr == AW'(REG_ZERO)) begin
                    drop_r0 <= 1'b1;
                end else begin
                    we3 <= 1'b1;
                    wa3 <= sel_addr;
                    wd3 <= sel_data;
                end
            end
        end
    end

    a_ready_onehot0: assert property (@(posedge clk) disable iff (!reset) $onehot0(req_ready));

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Scoreboard bench for regfile_wr_arbiter: per-port request queues feed the DUT,
// a reference arbiter predicts each grant and the registered write it produces.
module tb_regfile_wr_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 4;
    localparam int DW   = 16;
    localparam int IW   = 2;

    logic               clk = 1'b0;
    logic               reset;
    logic               stall;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               we3;
    logic [AW-1:0]      wa3;
    logic [DW-1:0]      wd3;
    logic [IW-1:0]      grant_id;
    logic               drop_r0;

    regfile_wr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .we3       (we3),
        .wa3       (wa3),
        .wd3       (wd3),
        .grant_id  (grant_id),
        .drop_r0   (drop_r0)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } item_t;

    typedef struct {
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [IW-1:0] id;
        logic          drop;
    } out_t;

    item_t pq[NREQ][$];
    out_t  sb[$];

    int n_chk  = 0;
    int n_fail = 0;

`ifdef REGFILE_WR_ARB_PRIO0_EN
    localparam int PTR_RST = 1;
`else
    localparam int PTR_RST = 0;
`endif

    int            mptr = PTR_RST;
    logic [AW-1:0] m_wa = '0;
    logic [DW-1:0] m_wd = '0;
    logic [IW-1:0] m_id = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_inputs();
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pq[i].size() != 0) begin
                req_valid[i]          = 1'b1;
                req_addr[i*AW +: AW]  = pq[i][0].a;
                req_data[i*DW +: DW]  = pq[i][0].d;
            end
        end
    endtask

    function automatic int ref_winner();
        int w = -1;
        if (stall) return -1;
`ifdef REGFILE_WR_ARB_PRIO0_EN
        if (req_valid[0]) return 0;
        for (int k = 0; k < NREQ - 1; k++) begin
            int j = 1 + ((mptr - 1 + k) % (NREQ - 1));
            if (w < 0 && req_valid[j]) w = j;
        end
`else
        for (int k = 0; k < NREQ; k++) begin
            int j = (mptr + k) % NREQ;
            if (w < 0 && req_valid[j]) w = j;
        end
`endif
        return w;
    endfunction

    // One arbitration cycle: predict, check ready, push expectation, clock, pop and compare.
    task automatic step();
        int            w;
        logic [NREQ-1:0] exp_rdy;
        item_t         it;
        out_t          e;
        drive_inputs();
        #1;
        w       = ref_winner();
        exp_rdy = (w >= 0) ? (NREQ'(1) << w) : '0;
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        if (w >= 0) begin
            it = pq[w].pop_front();
            m_id = IW'(w);
            if (it.a != '0) begin
                m_wa = it.a;
                m_wd = it.d;
                e = '{we: 1'b1, wa: m_wa, wd: m_wd, id: m_id, drop: 1'b0};
            end else begin
                e = '{we: 1'b0, wa: m_wa, wd: m_wd, id: m_id, drop: 1'b1};
            end
`ifdef REGFILE_WR_ARB_PRIO0_EN
            if (w != 0) begin
                mptr = (w + 1) % NREQ;
                if (mptr == 0) mptr = 1;
            end
`else
            mptr = (w + 1) % NREQ;
`endif
        end else begin
            e = '{we: 1'b0, wa: m_wa, wd: m_wd, id: m_id, drop: 1'b0};
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("we3",      32'(we3),      32'(e.we));
        check("wa3",      32'(wa3),      32'(e.wa));
        check("wd3",      32'(wd3),      32'(e.wd));
        check("grant_id", 32'(grant_id), 32'(e.id));
        check("drop_r0",  32'(drop_r0),  32'(e.drop));
    endtask

    function automatic bit pending();
        for (int i = 0; i < NREQ; i++) if (pq[i].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic run_drain(input int maxc);
        int c = 0;
        while (pending() && c < maxc) begin
            step();
            c++;
        end
        if (pending()) check("drain_timeout", 32'd1, 32'd0);
        step();
    endtask

    task automatic push(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
        item_t it;
        it.a = a;
        it.d = d;
        pq[p].push_back(it);
    endtask

    initial begin
        reset = 1'b0;
        stall = 1'b0;
        for (int i = 0; i < NREQ; i++) push(i, AW'(i + 8), DW'(16'hA000 + i));
        drive_inputs();
        #2;
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_we3",   32'(we3),       32'd0);
        check("rst_wa3",   32'(wa3),       32'd0);
        check("rst_wd3",   32'(wd3),       32'd0);
        check("rst_gid",   32'(grant_id),  32'd0);
        check("rst_drop",  32'(drop_r0),   32'd0);
        @(posedge clk);
        #1;
        check("rst_ready_edge", 32'(req_ready), 32'd0);
        reset = 1'b1;
        run_drain(20);

        // Continuous requests on all ports: grants rotate 0,1,2,3,0,...
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NREQ; i++) push(i, AW'(i + 1 + 4*r), DW'($urandom));
        run_drain(20);

        push(2, AW'(5), 16'hBEEF);
        run_drain(10);

        push(1, AW'(0), 16'h1234);
        run_drain(10);

        // Stall right after a grant: in-flight write completes, no new grants.
        push(1, AW'(3), 16'h3333);
        step();
        stall = 1'b1;
        push(0, AW'(6), 16'h0606);
        push(3, AW'(7), 16'h0707);
        for (int c = 0; c < 3; c++) step();
        stall = 1'b0;
        run_drain(10);

        // Reset while a write is in flight: it is lost and the pointer restarts.
        push(2, AW'(9), 16'h9999);
        step();
        reset = 1'b0;
        #1;
        check("midrst_we3",   32'(we3),       32'd0);
        check("midrst_wa3",   32'(wa3),       32'd0);
        check("midrst_ready", 32'(req_ready), 32'd0);
        mptr = PTR_RST;
        m_wa = '0;
        m_wd = '0;
        m_id = '0;
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Same register written by two ports: later grant must land last.
        push(3, AW'(4), 16'h1111);
        push(1, AW'(4), 16'h2222);
        run_drain(10);

        for (int c = 0; c < 80; c++) begin
            for (int i = 0; i < NREQ; i++)
                if (pq[i].size() == 0 && $urandom_range(0, 2) == 0)
                    push(i, AW'($urandom_range(0, 15)), DW'($urandom));
            stall = ($urandom_range(0, 4) == 0);
            step();
        end
        stall = 1'b0;
        run_drain(40);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
